// File: rtl/branch_cond_pkg.sv
// Shared definitions for the conditional-branch sequencer: FSM state
// encodings, branch opcodes, ALU operation codes and condition-mux selects.
// Optional feature macro (used by branch_cond_ctrl): BRANCH_COND_BLE_BGT_EN
package branch_cond_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COMPARE = 2'd1;
  localparam state_t ST_RESOLVE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_BNE = 6'h05;
  localparam logic [5:0] OPC_BLE = 6'h06;
  localparam logic [5:0] OPC_BGT = 6'h07;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam logic [1:0] SEL_ZERO  = 2'b00;
  localparam logic [1:0] SEL_NZERO = 2'b01;
  localparam logic [1:0] SEL_GT    = 2'b10;

endpackage

// File: rtl/branch_flag_reg.sv
// The three registered ALU flags that feed the condition mux data inputs.
// They load together on 'load' and otherwise hold; reset clears all three.
module branch_flag_reg (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic zero_d,
  input  logic nzero_d,
  input  logic gt_d,
  output logic flag_zero,
  output logic flag_nzero,
  output logic flag_gt
);

  // Capture the flag set when loaded, hold it otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_zero  <= 1'b0;
      flag_nzero <= 1'b0;
      flag_gt    <= 1'b0;
    end else if (load) begin
      flag_zero  <= zero_d;
      flag_nzero <= nzero_d;
      flag_gt    <= gt_d;
    end
  end

endmodule

// File: rtl/branch_cond_ctrl.sv
// Multicycle conditional-branch sequencer: ALU compare, flag capture,
// condition-mux select and taken resolution, then a one-cycle PC-write pulse.
// Optional feature macro: BRANCH_COND_BLE_BGT_EN enables BLE/BGT; without it
// those opcodes are treated as illegal and the gt flag is tied low.
module branch_cond_ctrl
  import branch_cond_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               alu_zero,
  input  logic               alu_gt,
  input  logic               cond_in,
  output logic               flag_zero,
  output logic               flag_nzero,
  output logic               flag_gt,
  output logic [1:0]         cond_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               pc_write,
  output logic               busy,
  output logic               done,
  output logic               ill
);

  state_t           state;
  state_t           state_nxt;
  logic [OPC_W-1:0] opc_q;
  logic             taken_q;
  logic             ill_q;
  logic [1:0]       sel_q;

  logic             req_ok;
  logic [1:0]       res_sel;
  logic             res_inv;
  logic             gt_d;

  // Returns {supported, invert, select[1:0]} for a branch opcode
  function automatic logic [3:0] decode(input logic [OPC_W-1:0] opc);
    logic [3:0] r;
    r = {1'b0, 1'b0, SEL_ZERO};
    if (opc == OPC_W'(OPC_BEQ)) r = {1'b1, 1'b0, SEL_ZERO};
    if (opc == OPC_W'(OPC_BNE)) r = {1'b1, 1'b0, SEL_NZERO};
`ifdef BRANCH_COND_BLE_BGT_EN
    if (opc == OPC_W'(OPC_BLE)) r = {1'b1, 1'b1, SEL_GT};
    if (opc == OPC_W'(OPC_BGT)) r = {1'b1, 1'b0, SEL_GT};
`endif
    return r;
  endfunction

  // Decode the incoming request and the latched branch being resolved
  always_comb begin
    logic [3:0] dreq;
    logic [3:0] dres;
    dreq    = decode(opcode);
    dres    = decode(opc_q);
    req_ok  = dreq[3];
    res_inv = dres[2];
    res_sel = dres[1:0];
  end

`ifdef BRANCH_COND_BLE_BGT_EN
  assign gt_d = alu_gt;
`else
  logic unused_alu_gt;
  assign unused_alu_gt = alu_gt;
  assign gt_d          = 1'b0;
`endif

  // Next-state logic: illegal requests skip straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = req_ok ? ST_COMPARE : ST_DONE;
      ST_COMPARE: state_nxt = ST_RESOLVE;
      ST_RESOLVE: state_nxt = ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, latched opcode, illegal flag, taken and held mux select
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      opc_q   <= '0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      sel_q   <= SEL_ZERO;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_ok) begin
              opc_q <= opcode;
              ill_q <= 1'b0;
            end else begin
              ill_q   <= 1'b1;
              taken_q <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          taken_q <= cond_in ^ res_inv;
          sel_q   <= res_sel;
        end
        default: ;
      endcase
    end
  end

  branch_flag_reg u_flags (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (state == ST_COMPARE),
    .zero_d     (alu_zero),
    .nzero_d    (~alu_zero),
    .gt_d       (gt_d),
    .flag_zero  (flag_zero),
    .flag_nzero (flag_nzero),
    .flag_gt    (flag_gt)
  );

  assign cond_sel = (state == ST_RESOLVE) ? res_sel : sel_q;
  assign alu_op   = (state == ST_COMPARE) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_NOP);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign pc_write = (state == ST_DONE) & taken_q;
  assign ill      = (state == ST_DONE) & ill_q;

endmodule

// File: tb/tb_branch_cond_ctrl.sv
// Directed testbench for branch_cond_ctrl with a combinational model of the
// downstream 3:1 condition mux closing the cond_in loop.
module tb_branch_cond_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       alu_gt;
  logic       cond_in;
  logic       flag_zero;
  logic       flag_nzero;
  logic       flag_gt;
  logic [1:0] cond_sel;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       busy;
  logic       done;
  logic       ill;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  always #5 clk = ~clk;

  // Downstream condition mux: In0 zero, In1 nzero, In2 gt
  assign cond_in = (cond_sel == 2'b00) ? flag_zero  :
                   (cond_sel == 2'b01) ? flag_nzero :
                   (cond_sel == 2'b10) ? flag_gt    : 1'b0;

  branch_cond_ctrl #(.OPC_W(6), .ALUOP_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .alu_gt     (alu_gt),
    .cond_in    (cond_in),
    .flag_zero  (flag_zero),
    .flag_nzero (flag_nzero),
    .flag_gt    (flag_gt),
    .cond_sel   (cond_sel),
    .alu_op     (alu_op),
    .pc_write   (pc_write),
    .busy       (busy),
    .done       (done),
    .ill        (ill)
  );

  // Advance one clock and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {20'd0, flag_zero, flag_nzero, flag_gt, cond_sel, alu_op, pc_write, busy, done, ill};
  endfunction

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 6'h00; alu_zero = 1'b0; alu_gt = 1'b0;

    // Reset and idle
    tick(); tick();
    check("reset_outs", all_outs(), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outs", all_outs(), 32'd0);
    end

    // BEQ taken
    start = 1'b1; opcode = 6'h04; alu_zero = 1'b1; alu_gt = 1'b0;
    tick();
    start = 1'b0;
    check("beq_cmp_busy", busy, 1);
    check("beq_cmp_aluop", alu_op, 3'b010);
    check("beq_cmp_done", done, 0);
    tick();
    check("beq_res_sel", cond_sel, 2'b00);
    check("beq_res_fz", flag_zero, 1);
    check("beq_res_fnz", flag_nzero, 0);
    check("beq_res_aluop", alu_op, 3'b000);
    check("beq_res_done", done, 0);
    tick();
    check("beq_done", done, 1);
    check("beq_pcw", pc_write, 1);
    check("beq_ill", ill, 0);
    check("beq_busy", busy, 1);
    tick();
    check("beq_after", {busy, done, pc_write}, 3'b000);

    // BNE not taken
    start = 1'b1; opcode = 6'h05; alu_zero = 1'b1;
    tick();
    start = 1'b0;
    check("bne_cmp_aluop", alu_op, 3'b010);
    tick();
    check("bne_res_sel", cond_sel, 2'b01);
    check("bne_res_fnz", flag_nzero, 0);
    tick();
    check("bne_done", {done, pc_write}, 2'b10);
    tick();
    check("bne_sel_hold", cond_sel, 2'b01);
    check("bne_idle", busy, 0);

    // BLE via inversion
    start = 1'b1; opcode = 6'h06; alu_zero = 1'b0; alu_gt = 1'b0;
`ifdef BRANCH_COND_BLE_BGT_EN
    tick();
    start = 1'b0;
    check("ble_cmp_busy", busy, 1);
    check("ble_cmp_done", done, 0);
    tick();
    check("ble_res_sel", cond_sel, 2'b10);
    check("ble_res_cin", cond_in, 0);
    tick();
    check("ble_done", {done, pc_write, ill}, 3'b110);
    tick();
    check("ble_idle", busy, 0);

    // BGT taken
    start = 1'b1; opcode = 6'h07; alu_zero = 1'b0; alu_gt = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("bgt_res_sel", cond_sel, 2'b10);
    check("bgt_res_fgt", flag_gt, 1);
    tick();
    check("bgt_done", {done, pc_write, ill}, 3'b110);
    tick();
`else
    tick();
    start = 1'b0;
    check("ble_ill_done", {done, pc_write, ill, busy}, 4'b1011);
    check("ble_ill_aluop", alu_op, 3'b000);
    check("ble_ill_sel", cond_sel, 2'b01);
    tick();
    check("ble_ill_idle", {busy, done, ill}, 3'b000);
    start = 1'b1; opcode = 6'h07; alu_gt = 1'b1;
    tick();
    start = 1'b0;
    check("bgt_ill_done", {done, pc_write, ill}, 3'b101);
    tick();
    check("bgt_ill_fgt", flag_gt, 0);
`endif

    // Illegal opcode
    start = 1'b1; opcode = 6'h08;
    tick();
    start = 1'b0;
    check("ill_done", {done, ill, pc_write, busy}, 4'b1101);
    check("ill_aluop", alu_op, 3'b000);
    tick();
    check("ill_idle", {busy, done, ill}, 3'b000);

    // Start pulsed during COMPARE is ignored, not queued
    start = 1'b1; opcode = 6'h04; alu_zero = 1'b0;
    tick();
    check("ign_cmp", alu_op, 3'b010);
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) begin
        done_cnt++;
        check("ign_pcw", pc_write, 0);
      end
      tick();
    end
    check("ign_done_count", done_cnt, 1);
    check("ign_flags", {flag_zero, flag_nzero}, 2'b01);
    check("ign_idle", busy, 0);

    // Reset during RESOLVE of a taken BEQ
    start = 1'b1; opcode = 6'h04; alu_zero = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_res_cin", cond_in, 1);
    reset_n = 1'b0;
    tick();
    check("rst_outs", all_outs(), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_no_pcw", all_outs(), 32'd0);

    // Start together with reset: reset wins
    start = 1'b1; reset_n = 1'b0;
    tick();
    start = 1'b0; reset_n = 1'b1;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_outs", all_outs(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
